// File: rtl/axi_dram_arbiter.sv
// N-master to 1-slave AXI4 arbiter: round-robin AR/AW, W locked to AW owner, R/B routed by ID prefix.
// Optional per-master grant counters are enabled by defining ARB_PERF_EN.
module axi_dram_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 4,
  parameter int IDX_BITS  = $clog2(N_MASTERS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_MASTERS-1:0]                 m_ar_valid,
  output logic [N_MASTERS-1:0]                 m_ar_ready,
  input  logic [N_MASTERS*ADDR_BITS-1:0]       m_ar_addr,
  input  logic [N_MASTERS*ID_BITS-1:0]         m_ar_id,
  input  logic [N_MASTERS*8-1:0]               m_ar_len,
  input  logic [N_MASTERS*3-1:0]               m_ar_size,
  input  logic [N_MASTERS-1:0]                 m_aw_valid,
  output logic [N_MASTERS-1:0]                 m_aw_ready,
  input  logic [N_MASTERS*ADDR_BITS-1:0]       m_aw_addr,
  input  logic [N_MASTERS*ID_BITS-1:0]         m_aw_id,
  input  logic [N_MASTERS*8-1:0]               m_aw_len,
  input  logic [N_MASTERS*3-1:0]               m_aw_size,
  input  logic [N_MASTERS-1:0]                 m_w_valid,
  output logic [N_MASTERS-1:0]                 m_w_ready,
  input  logic [N_MASTERS*DATA_BITS-1:0]       m_w_data,
  input  logic [N_MASTERS*DATA_BITS/8-1:0]     m_w_strb,
  input  logic [N_MASTERS-1:0]                 m_w_last,
  output logic [N_MASTERS-1:0]                 m_r_valid,
  input  logic [N_MASTERS-1:0]                 m_r_ready,
  output logic [ID_BITS-1:0]                   m_r_id,
  output logic [DATA_BITS-1:0]                 m_r_data,
  output logic [1:0]                           m_r_resp,
  output logic                                 m_r_last,
  output logic [N_MASTERS-1:0]                 m_b_valid,
  input  logic [N_MASTERS-1:0]                 m_b_ready,
  output logic [ID_BITS-1:0]                   m_b_id,
  output logic [1:0]                           m_b_resp,
  output logic                                 s_ar_valid,
  input  logic                                 s_ar_ready,
  output logic [ADDR_BITS-1:0]                 s_ar_addr,
  output logic [ID_BITS+IDX_BITS-1:0]          s_ar_id,
  output logic [7:0]                           s_ar_len,
  output logic [2:0]                           s_ar_size,
  output logic                                 s_aw_valid,
  input  logic                                 s_aw_ready,
  output logic [ADDR_BITS-1:0]                 s_aw_addr,
  output logic [ID_BITS+IDX_BITS-1:0]          s_aw_id,
  output logic [7:0]                           s_aw_len,
  output logic [2:0]                           s_aw_size,
  output logic                                 s_w_valid,
  input  logic                                 s_w_ready,
  output logic [DATA_BITS-1:0]                 s_w_data,
  output logic [DATA_BITS/8-1:0]               s_w_strb,
  output logic                                 s_w_last,
  input  logic                                 s_r_valid,
  output logic                                 s_r_ready,
  input  logic [ID_BITS+IDX_BITS-1:0]          s_r_id,
  input  logic [DATA_BITS-1:0]                 s_r_data,
  input  logic [1:0]                           s_r_resp,
  input  logic                                 s_r_last,
  input  logic                                 s_b_valid,
  output logic                                 s_b_ready,
  input  logic [ID_BITS+IDX_BITS-1:0]          s_b_id,
  input  logic [1:0]                           s_b_resp,
  output logic                                 dbg_w_state
`ifdef ARB_PERF_EN
  ,
  output logic [N_MASTERS*32-1:0]              perf_rd_grants,
  output logic [N_MASTERS*32-1:0]              perf_wr_grants
`endif
);

  localparam int SID_BITS  = ID_BITS + IDX_BITS;
  localparam int STRB_BITS = DATA_BITS / 8;

  // Every channel uses AXI valid/ready: a beat transfers on the rising edge where
  // both are high, and a source holds its payload stable while valid && !ready.

  typedef enum logic {W_IDLE = 1'b0, W_BURST = 1'b1} w_state_t;

  w_state_t            state_q, state_d;
  logic [IDX_BITS-1:0] w_owner;
  logic [IDX_BITS-1:0] rr_ar, rr_aw, ar_lock_idx, aw_lock_idx;
  logic                ar_locked, aw_locked;
  logic [IDX_BITS-1:0] ar_win, aw_win;
  logic                ar_hs, aw_hs, w_hs;

  // First requester at or after ptr, searching upward with wrap.
  function automatic logic [IDX_BITS-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                  input logic [IDX_BITS-1:0] ptr);
    logic [N_MASTERS-1:0] rot;
    logic [IDX_BITS-1:0]  pick;
    logic                 found;
    int                   j;
    rot   = N_MASTERS'({req, req} >> ptr);
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!found && rot[k]) begin
        j = int'(ptr) + k;
        if (j >= N_MASTERS) j = j - N_MASTERS;
        pick  = IDX_BITS'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_BITS-1:0] next_idx(input logic [IDX_BITS-1:0] idx);
    if (idx == IDX_BITS'(N_MASTERS - 1)) return '0;
    return idx + IDX_BITS'(1);
  endfunction

  // Read address: a locked grant keeps the downstream request stable until accepted.
  always_comb begin
    ar_win     = ar_locked ? ar_lock_idx : rr_pick(m_ar_valid, rr_ar);
    s_ar_valid = 1'b0;
    s_ar_addr  = '0;
    s_ar_id    = '0;
    s_ar_len   = '0;
    s_ar_size  = '0;
    m_ar_ready = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (ar_win == IDX_BITS'(i)) begin
        s_ar_valid    = !reset && m_ar_valid[i];
        s_ar_addr     = m_ar_addr[i*ADDR_BITS +: ADDR_BITS];
        s_ar_id       = {ar_win, m_ar_id[i*ID_BITS +: ID_BITS]};
        s_ar_len      = m_ar_len[i*8 +: 8];
        s_ar_size     = m_ar_size[i*3 +: 3];
        m_ar_ready[i] = !reset && m_ar_valid[i] && s_ar_ready;
      end
    end
  end

  assign ar_hs = s_ar_valid && s_ar_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ar       <= '0;
      ar_locked   <= 1'b0;
      ar_lock_idx <= '0;
    end else if (ar_hs) begin
      ar_locked <= 1'b0;
      rr_ar     <= next_idx(ar_win);
    end else begin
      ar_locked   <= s_ar_valid;
      ar_lock_idx <= ar_win;
    end
  end

  // Write address: same scheme, but no grant while a write burst is still open.
  always_comb begin
    aw_win     = aw_locked ? aw_lock_idx : rr_pick(m_aw_valid, rr_aw);
    s_aw_valid = 1'b0;
    s_aw_addr  = '0;
    s_aw_id    = '0;
    s_aw_len   = '0;
    s_aw_size  = '0;
    m_aw_ready = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (aw_win == IDX_BITS'(i)) begin
        s_aw_valid    = !reset && (state_q == W_IDLE) && m_aw_valid[i];
        s_aw_addr     = m_aw_addr[i*ADDR_BITS +: ADDR_BITS];
        s_aw_id       = {aw_win, m_aw_id[i*ID_BITS +: ID_BITS]};
        s_aw_len      = m_aw_len[i*8 +: 8];
        s_aw_size     = m_aw_size[i*3 +: 3];
        m_aw_ready[i] = !reset && (state_q == W_IDLE) && m_aw_valid[i] && s_aw_ready;
      end
    end
  end

  assign aw_hs = s_aw_valid && s_aw_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_aw       <= '0;
      aw_locked   <= 1'b0;
      aw_lock_idx <= '0;
    end else if (aw_hs) begin
      aw_locked <= 1'b0;
      rr_aw     <= next_idx(aw_win);
    end else begin
      aw_locked   <= s_aw_valid;
      aw_lock_idx <= aw_win;
    end
  end

  // Write FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= W_IDLE;
      w_owner <= '0;
    end else begin
      state_q <= state_d;
      if (aw_hs) w_owner <= aw_win;
    end
  end

  // Write FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:  if (aw_hs) state_d = W_BURST;
      W_BURST: if (w_hs && s_w_last) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs: only the burst owner's W channel is connected.
  always_comb begin
    s_w_valid = 1'b0;
    s_w_data  = '0;
    s_w_strb  = '0;
    s_w_last  = 1'b0;
    m_w_ready = '0;
    if (!reset && state_q == W_BURST) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (w_owner == IDX_BITS'(i)) begin
          s_w_valid    = m_w_valid[i];
          s_w_data     = m_w_data[i*DATA_BITS +: DATA_BITS];
          s_w_strb     = m_w_strb[i*STRB_BITS +: STRB_BITS];
          s_w_last     = m_w_last[i];
          m_w_ready[i] = s_w_ready;
        end
      end
    end
  end

  assign w_hs        = s_w_valid && s_w_ready;
  assign dbg_w_state = state_q;

  // Response routing: an index with no matching master is accepted and dropped.
  always_comb begin
    m_r_valid = '0;
    s_r_ready = !reset;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (int'(s_r_id[SID_BITS-1 -: IDX_BITS]) == i) begin
        m_r_valid[i] = !reset && s_r_valid;
        s_r_ready    = !reset && m_r_ready[i];
      end
    end
  end

  always_comb begin
    m_b_valid = '0;
    s_b_ready = !reset;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (int'(s_b_id[SID_BITS-1 -: IDX_BITS]) == i) begin
        m_b_valid[i] = !reset && s_b_valid;
        s_b_ready    = !reset && m_b_ready[i];
      end
    end
  end

  assign m_r_id   = s_r_id[ID_BITS-1:0];
  assign m_r_data = s_r_data;
  assign m_r_resp = s_r_resp;
  assign m_r_last = s_r_last;
  assign m_b_id   = s_b_id[ID_BITS-1:0];
  assign m_b_resp = s_b_resp;

`ifdef ARB_PERF_EN
  // Free-running per-master grant counters, wrapping naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_rd_grants <= '0;
      perf_wr_grants <= '0;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (ar_hs && ar_win == IDX_BITS'(i))
          perf_rd_grants[i*32 +: 32] <= perf_rd_grants[i*32 +: 32] + 32'd1;
        if (aw_hs && aw_win == IDX_BITS'(i))
          perf_wr_grants[i*32 +: 32] <= perf_wr_grants[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/axi_dram_arbiter.md
Name: axi_dram_arbiter

Overview:
- N-master to 1-slave AXI4 arbiter that shares one simulated-DRAM AXI port among several requesters, e.g. core memory port, DMA engine and serial adapter.
- Round-robin arbitration on AR and AW.
- Write data is locked to the AW winner until its last beat.
- R and B responses are routed back by master-index bits prefixed onto the downstream ID.
- Sits directly in front of the DRAM model on the simulation harness memory path.

Parameters:
- N_MASTERS, 2, number of upstream masters (must be ≥2).
- ADDR_BITS, 32, address width.
- DATA_BITS, 64, data width.
- ID_BITS, 4, upstream ID width.
- IDX_BITS, $clog2(N_MASTERS), master-index width; downstream ID width is ID_BITS+IDX_BITS.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_ar_valid/m_ar_ready  in/out  N  per-master read-address handshake
- m_ar_addr  in  N*ADDR_BITS  packed; master i at slice i
- m_ar_id  in  N*ID_BITS  packed
- m_ar_len  in  N*8  packed
- m_ar_size  in  N*3  packed
- m_aw_valid/m_aw_ready, m_aw_addr, m_aw_id, m_aw_len, m_aw_size  as AR, write-address channel
- m_w_valid/m_w_ready  in/out  N  per-master write-data handshake
- m_w_data  in  N*DATA_BITS  packed
- m_w_strb  in  N*DATA_BITS/8  packed
- m_w_last  in  N  packed
- m_r_valid  out  N  per-master read-data valid
- m_r_ready  in  N  per-master read-data ready
- m_r_id  out  ID_BITS  broadcast
- m_r_data  out  DATA_BITS  broadcast
- m_r_resp  out  2  broadcast
- m_r_last  out  1  broadcast
- m_b_valid  out  N  per-master write-response valid
- m_b_ready  in  N  per-master write-response ready
- m_b_id  out  ID_BITS  broadcast
- m_b_resp  out  2  broadcast
- s_ar_valid/s_ar_ready, s_ar_addr, s_ar_len, s_ar_size  out/in  downstream read address
- s_ar_id  out  ID_BITS+IDX_BITS  {master index, upstream ID}
- s_aw_*  same as s_ar_*, downstream write address
- s_w_valid/s_w_ready, s_w_data, s_w_strb, s_w_last  downstream write data
- s_r_valid/s_r_ready, s_r_id, s_r_data, s_r_resp, s_r_last  downstream read data
- s_b_valid/s_b_ready, s_b_id, s_b_resp  downstream write response

Behaviour:
- Reset:
  - While reset is high, every valid/ready output is 0.
  - AR and AW round-robin pointers reset to 0; grant locks clear; write FSM to W_IDLE.
- AR arbitration (combinational grant, registered lock):
  - When unlocked, grant the first requesting master at or after rr_ar, searching upward with wrap N-1→0.
  - s_ar_* is driven from the granted master. Only the granted master sees m_ar_ready = s_ar_ready.
  - If s_ar_valid && !s_ar_ready, lock the grant, so the downstream request stays stable until accepted.
  - On handshake: unlock and set rr_ar = winner+1 mod N. Zero added latency.
- AW arbitration: identical scheme, but a grant is permitted only in state W_IDLE.
- Write FSM:
  - W_IDLE→W_BURST(owner=winner) on s_aw handshake.
  - In W_BURST, only the owner's W channel is connected (s_w_* = owner's; m_w_ready[owner] = s_w_ready). All other m_w_ready are 0.
  - W_BURST→W_IDLE on s_w handshake with w_last.
  - W never passes on the AW handshake cycle; the first beat moves the following cycle at the earliest.
  - W asserted by a master before its AW is granted waits, with no error.
- Response routing:
  - m_r_valid[s_r_id[top IDX_BITS]] = s_r_valid; s_r_ready = m_r_ready of that master.
  - m_r_id = s_r_id[ID_BITS-1:0]. B is routed the same way.
  - An index ≥ N_MASTERS drops the beat: s_r_ready/s_b_ready = 1 and no m_valid.
- Simultaneous events: AR and AW arbitration are independent and may both grant in the same cycle. R and B routing is fully independent of arbitration.
- Reset mid-burst: the FSM returns to W_IDLE, the lock clears and the partial burst is abandoned. The integrator must reset downstream alongside.

Optional Feature:
- ARB_PERF_EN.
- When defined, adds outputs perf_rd_grants and perf_wr_grants (N*32, packed). Each is a per-master 32-bit counter incremented on that master's AR or AW handshake. Counters wrap at 2^32-1→0 and clear on reset.
- When undefined, these ports and counters are absent.

Test Plan:
- Masters 0 and 1 hold m_ar_valid continuously with s_ar_ready=1 → grants alternate 0,1,0,1; s_ar_id = {idx, id}, e.g. master 1 id 0x3 → 0x13.
- Master 0 AR presented with s_ar_ready=0 for 5 cycles while master 1 raises valid → s_ar_addr stays master 0's; master 1 is granted the cycle after master 0's handshake.
- Master 1 AW len=3, then master 0 AW → master 0 AW is blocked until master 1's 4th W beat with last; master 0's W is ignored until then.
- Downstream R with s_r_id=0x05 and 0x12 → m_r_valid[0] with id 0x5, then m_r_valid[1] with id 0x2; backpressure via m_r_ready[1]=0 holds s_r_ready=0.
- Reset asserted during beat 2 of a 4-beat write → all valid/ready outputs are 0; after reset, a new AW is granted immediately.
- With ARB_PERF_EN: 3 reads from master 0 and 2 writes from master 1 → perf_rd_grants[0]=3, perf_wr_grants[1]=2; counter preloaded to 0xFFFFFFFF wraps to 0.
